// File: rtl/pipe_credit_rx.sv
// Receive-end buffer for a fixed-latency, credit-flow-controlled data pipe.
// Every arriving word is absorbed into a circular buffer and presented
// show-ahead to the consumer. One credit pulse is returned per consumed word.
// The producer never sends without a credit, so there is no back-pressure
// toward the pipe. A word that arrives when the buffer is full and nothing is
// popped in the same cycle is dropped, and the sticky overflow flag is raised.

module pipe_credit_rx #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  input  logic              i_ready,
  output logic              o_credit,
  output logic [CNT_W-1:0]  o_count,
  output logic              o_overflow
);

  localparam int unsigned PTR_W = CNT_W - 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_credit;
  logic              r_overflow;

  logic              w_full;
  logic              w_pop;
  logic              w_push;
  logic              w_drop;
  logic [CNT_W-1:0]  w_count_next;

  // Handshake decode; everything here depends only on registered state plus
  // i_valid / i_ready, and none of it feeds o_valid or o_data.
  always_comb begin
    w_full = (r_count == CNT_W'(DEPTH));
    w_pop  = o_valid & i_ready;
    // A pop in the same cycle frees the slot the arriving word needs.
    w_push = i_valid & (~w_full | w_pop);
    w_drop = i_valid & w_full & ~w_pop;
  end

  // Occupancy next-state: a push and a pop together leave the count unchanged.
  always_comb begin
    w_count_next = r_count;
    unique case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + 1'b1;
      2'b01:   w_count_next = r_count - 1'b1;
      default: w_count_next = r_count;
    endcase
  end

  // Pointers, count, credit pulse and sticky overflow, cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_credit   <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count  <= w_count_next;
      r_credit <= w_pop;
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  // Storage array; contents are don't-care after reset, so it is not cleared.
  always_ff @(posedge clk) begin
    if (w_push && !reset) r_mem[r_wr_ptr] <= i_data;
  end

  // Show-ahead outputs driven purely from registered state.
  always_comb begin
    o_valid    = (r_count != '0);
    o_data     = r_mem[r_rd_ptr];
    o_count    = r_count;
    o_credit   = r_credit;
    o_overflow = r_overflow;
  end

endmodule

// File: tb/tb_pipe_credit_rx.sv
// Directed bench for pipe_credit_rx: a table of per-cycle vectors followed by
// a credit-respecting streaming sequence with random consumer stalls.

module tb_pipe_credit_rx;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;

  logic              clk;
  logic              reset;
  logic              i_valid;
  logic [DATA_W-1:0] i_data;
  logic              o_valid;
  logic [DATA_W-1:0] o_data;
  logic              i_ready;
  logic              o_credit;
  logic [CNT_W-1:0]  o_count;
  logic              o_overflow;

  int checks;
  int failures;

  pipe_credit_rx #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W)
  ) u_dut (
    .clk        (clk),
    .reset      (reset),
    .i_valid    (i_valid),
    .i_data     (i_data),
    .o_valid    (o_valid),
    .o_data     (o_data),
    .i_ready    (i_ready),
    .o_credit   (o_credit),
    .o_count    (o_count),
    .o_overflow (o_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        vld;
    logic [31:0] data;
    logic        rdy;
    logic        ev;
    logic [31:0] ed;
    logic [2:0]  ec;
    logic        ecr;
    logic        eov;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int rst, input int vld, input int data, input int rdy,
                     input int ev, input int ed, input int ec, input int ecr,
                     input int eov);
    vec_t v;
    v.rst  = (rst != 0);
    v.vld  = (vld != 0);
    v.data = 32'(data);
    v.rdy  = (rdy != 0);
    v.ev   = (ev != 0);
    v.ed   = 32'(ed);
    v.ec   = 3'(ec);
    v.ecr  = (ecr != 0);
    v.eov  = (eov != 0);
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int step, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step=%0d actual=0x%0h required=0x%0h", name, step, act, exp);
    end
  endtask

  // Streaming sequence state.
  logic       dp_v [2];
  logic [7:0] dp_d [2];
  logic       cp   [2];
  int         credits;
  int         sent;
  int         exp_next;
  int         credit_pulses;
  int         ovf_seen;
  int         cyc;

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    i_valid  = 1'b0;
    i_data   = '0;
    i_ready  = 1'b0;

    // rst vld data rdy | ev ed cnt credit ovf  (expected state after the edge)
    add(1, 0, 'h00, 0,  0, 'h00, 0, 0, 0);
    // basic order
    add(0, 1, 'hA1, 0,  1, 'hA1, 1, 0, 0);
    add(0, 1, 'hA2, 0,  1, 'hA1, 2, 0, 0);
    add(0, 1, 'hA3, 0,  1, 'hA1, 3, 0, 0);
    add(0, 0, 'h00, 1,  1, 'hA2, 2, 1, 0);
    add(0, 0, 'h00, 1,  1, 'hA3, 1, 1, 0);
    add(0, 0, 'h00, 1,  0, 'h00, 0, 1, 0);
    add(0, 0, 'h00, 1,  0, 'h00, 0, 0, 0);
    // fill, then push at full with a simultaneous pop
    add(0, 1, 'hB1, 0,  1, 'hB1, 1, 0, 0);
    add(0, 1, 'hB2, 0,  1, 'hB1, 2, 0, 0);
    add(0, 1, 'hB3, 0,  1, 'hB1, 3, 0, 0);
    add(0, 1, 'hB4, 0,  1, 'hB1, 4, 0, 0);
    add(0, 1, 'hB5, 1,  1, 'hB2, 4, 1, 0);
    add(0, 0, 'h00, 0,  1, 'hB2, 4, 0, 0);
    // overflow at full: 0xCC is dropped
    add(0, 1, 'hCC, 0,  1, 'hB2, 4, 0, 1);
    add(0, 0, 'h00, 1,  1, 'hB3, 3, 1, 1);
    add(0, 0, 'h00, 1,  1, 'hB4, 2, 1, 1);
    add(0, 0, 'h00, 1,  1, 'hB5, 1, 1, 1);
    add(0, 0, 'h00, 1,  0, 'h00, 0, 1, 1);
    // empty corner: ready while empty does nothing
    add(0, 0, 'h00, 1,  0, 'h00, 0, 0, 1);
    add(0, 0, 'h00, 1,  0, 'h00, 0, 0, 1);
    add(0, 1, 'h5A, 1,  1, 'h5A, 1, 0, 1);
    add(0, 0, 'h00, 1,  0, 'h00, 0, 1, 1);
    add(0, 0, 'h00, 1,  0, 'h00, 0, 0, 1);
    // reset clears the sticky flag
    add(1, 0, 'h00, 0,  0, 'h00, 0, 0, 0);
    // reset mid-stream, with an arrival during reset that must be ignored
    add(0, 1, 'h01, 0,  1, 'h01, 1, 0, 0);
    add(0, 1, 'h02, 0,  1, 'h01, 2, 0, 0);
    add(0, 1, 'h03, 0,  1, 'h01, 3, 0, 0);
    add(0, 0, 'h00, 1,  1, 'h02, 2, 1, 0);
    add(1, 1, 'h99, 1,  0, 'h00, 0, 0, 0);
    add(0, 1, 'h77, 0,  1, 'h77, 1, 0, 0);
    add(0, 0, 'h00, 1,  0, 'h00, 0, 1, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      reset   = vecs[i].rst;
      i_valid = vecs[i].vld;
      i_data  = vecs[i].data;
      i_ready = vecs[i].rdy;
      @(posedge clk);
      #1;
      check("o_valid", i, 32'(o_valid), 32'(vecs[i].ev));
      check("o_count", i, 32'(o_count), 32'(vecs[i].ec));
      check("o_credit", i, 32'(o_credit), 32'(vecs[i].ecr));
      check("o_overflow", i, 32'(o_overflow), 32'(vecs[i].eov));
      if (vecs[i].ev) check("o_data", i, o_data, vecs[i].ed);
    end

    // Wrap-around stream: producer with DEPTH credits, 2-stage data pipe and
    // 2-stage credit return pipe, consumer stalling at random.
    reset   = 1'b1;
    i_valid = 1'b0;
    i_ready = 1'b0;
    @(posedge clk);
    #1;
    reset         = 1'b0;
    credits       = DEPTH;
    sent          = 0;
    exp_next      = 0;
    credit_pulses = 0;
    ovf_seen      = 0;
    for (int k = 0; k < 2; k++) begin
      dp_v[k] = 1'b0;
      dp_d[k] = '0;
      cp[k]   = 1'b0;
    end
    cyc = 0;
    while (!(exp_next == 20 && credits == int'(DEPTH) && !dp_v[0] && !dp_v[1]) &&
           cyc < 2000) begin
      cyc++;
      i_valid = dp_v[1];
      i_data  = 32'(dp_d[1]);
      dp_v[1] = dp_v[0];
      dp_d[1] = dp_d[0];
      dp_v[0] = 1'b0;
      if (credits > 0 && sent < 20 && $urandom_range(0, 3) != 0) begin
        dp_v[0] = 1'b1;
        dp_d[0] = 8'(sent);
        sent++;
        credits--;
      end
      i_ready = ($urandom_range(0, 2) != 0);
      if (o_valid && i_ready) begin
        check("stream_data", exp_next, o_data, 32'(exp_next));
        exp_next++;
      end
      @(posedge clk);
      #1;
      if (o_overflow) ovf_seen = 1;
      if (cp[1]) credits++;
      cp[1] = cp[0];
      cp[0] = o_credit;
      if (o_credit) credit_pulses++;
    end
    i_valid = 1'b0;
    i_ready = 1'b0;
    check("stream_words", cyc, 32'(exp_next), 32'd20);
    check("stream_credits", cyc, 32'(credit_pulses), 32'd20);
    check("stream_overflow", cyc, 32'(ovf_seen), 32'd0);
    check("stream_final_count", cyc, 32'(o_count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_credit_rx.md
# pipe_credit_rx

Receive-end buffer for a fixed-latency, credit-flow-controlled data pipe. A producer pushes words into a pipeline of registered stages (a single-bit or vector delay chain), and the words emerge here several cycles later. This block absorbs every word that arrives, presents words to the local consumer with a valid/ready handshake, and returns one credit pulse per consumed word. The producer keeps a credit counter initialised to `DEPTH` and never sends without a credit, so the buffer never needs to back-pressure the pipe.

## Interface
Parameters:
- `DATA_W`, 32, width of each data word.
- `DEPTH`, 4, buffer entries; must be a power of two and ≥2; equals the producer's initial credit count.
- `CNT_W`, $clog2(DEPTH)+1, width of the occupancy count.

Ports (single clock; reset is synchronous and active-high):
- `clk` in 1: sole clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high; clears all state.
- `i_valid` in 1: a word arrives from the pipe this cycle; there is no ready.
- `i_data` in `DATA_W`: arriving word, sampled when `i_valid`=1.
- `o_valid` out 1: head word available to the consumer.
- `o_data` out `DATA_W`: head word; held stable while `o_valid`=1 and `i_ready`=0.
- `i_ready` in 1: consumer accepts the head word. A pop occurs when `o_valid` & `i_ready`.
- `o_credit` out 1: one-cycle pulse per pop; goes back to the producer through its own delay pipe.
- `o_count` out `CNT_W`: current occupancy, 0..`DEPTH`.
- `o_overflow` out 1: sticky error flag; set when a word arrives while full with no simultaneous pop.

## Operation
- Storage: a circular buffer of `DEPTH` entries. It has a write pointer and a read pointer, each `CNT_W-1` bits wide, and they wrap modulo `DEPTH` naturally. An occupancy counter tracks fill level.
- Push occurs when `i_valid`=1 and either (`o_count` < `DEPTH`) or (a pop happens in the same cycle).
  - On push: write `i_data` at the write pointer, then increment the write pointer.
- Pop occurs when `o_valid`=1 and `i_ready`=1.
  - On pop: increment the read pointer.
  - Register `o_credit`=1 for the next cycle.
- Count update:
  - push only: +1
  - pop only: −1
  - both, or neither: unchanged
- Show-ahead read: `o_data` is the storage entry at the read pointer. `o_valid` = (`o_count` != 0). Both are functions of registered state only, with no combinational path from `i_valid` or `i_data`.
- Boundary cases:
  - Empty plus arrival: no bypass. The word becomes visible the next cycle.
  - Full plus arrival with a same-cycle pop: the push is accepted; count stays at `DEPTH`.
  - Full plus arrival without a pop: the word is dropped; pointers and count are unchanged; `o_overflow` is set and stays set until reset.
  - `i_ready` while empty: no effect; no credit is issued.
- Reset at any point, including mid-stream:
  - pointers and count go to 0;
  - `o_valid`=0, `o_credit`=0, `o_overflow`=0;
  - stored data is don't-care.
  - The producer is reset in the same cycle and re-initialises to `DEPTH` credits. Arrivals during reset are ignored.

## Timing
- Arrival to visibility: a word with `i_valid` at edge N produces `o_valid`=1 and `o_data`=word after edge N, so it can be popped in cycle N+1.
- Pop to credit: a pop at edge N produces `o_credit`=1 for exactly the cycle after edge N.
- Throughput: one push and one pop per cycle, sustained indefinitely. `o_credit` may therefore stay high on consecutive cycles, one pulse-cycle per pop.
- Round trip: total round-trip latency is (pipe latency + 1 + credit pipe latency). With `DEPTH` ≥ that round trip, a producer with `DEPTH` credits sustains full rate. Sizing is a system-level choice; this block does not enforce it.
- First cycle after `reset` deasserts: arrivals are accepted normally.

## Test plan
- Basic order: after reset, push 0xA1, 0xA2, 0xA3 on consecutive cycles with `i_ready`=0.
  - `o_count` goes 1, 2, 3; `o_data`=0xA1.
  - Then hold `i_ready`=1: pops yield 0xA1, 0xA2, 0xA3 in order.
  - `o_credit` is high on 3 consecutive cycles, each one cycle after its pop.
- Full and simultaneous: fill to `DEPTH`=4; `o_valid`=1 and `o_count`=4.
  - Push 0xB5 with `i_ready`=1 in the same cycle: accepted, count stays 4, `o_overflow`=0.
  - 0xB5 is output 4th-in-line after the pop.
- Overflow: at full, push 0xCC with `i_ready`=0.
  - 0xCC is never output; count stays 4; `o_overflow`=1.
  - After draining, `o_overflow` remains 1 until `reset`.
- Wrap-around: stream 20 words (values 0..19) with random `i_ready` under a credit-respecting producer model.
  - All 20 words are output in order; total `o_credit` pulses = 20; `o_overflow`=0 throughout.
- Empty corner: with the buffer empty, hold `i_ready`=1 with no arrivals.
  - `o_valid`=0 and `o_credit`=0 throughout.
  - A single arrival 0x5A becomes visible one cycle later and is popped immediately; `o_credit` pulses once.
- Reset mid-stream: with 3 words stored and pops in progress, assert `reset` for 1 cycle.
  - Next cycle: `o_valid`=0, `o_count`=0, `o_credit`=0, `o_overflow`=0.
  - A new word 0x77 pushed right after reset is output first.
